// File: rtl/ctrl_decode_if.sv
// ctrl_decode_if: IF/ID -> decode -> ID/EX bundle for ctrl_decode_stage.
//   master: instruction source / flush controller (drives id_*, flush)
//   slave : decode stage (drives id_ready, stall and all ex_* fields)
//   id_valid/id_instr/id_ready : instruction handshake from IF/ID
//   flush                      : taken branch/jump in EX
//   ex_*                       : registered ID/EX control and register indices
//   stall                      : load-use bubble being inserted
interface ctrl_decode_if #(
    parameter int unsigned REG_AW = 5
) ();
    logic              id_valid;
    logic [31:0]       id_instr;
    logic              id_ready;
    logic              flush;
    logic              ex_valid;
    logic [1:0]        ex_ALUop;
    logic              ex_ALUsrc;
    logic              ex_MtoR;
    logic              ex_regwrite;
    logic              ex_memread;
    logic              ex_memwrite;
    logic              ex_branch;
    logic              ex_jump;
    logic              ex_illegal;
    logic [REG_AW-1:0] ex_rd;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic              stall;

    modport master (
        output id_valid, id_instr, flush,
        input  id_ready, ex_valid, ex_ALUop, ex_ALUsrc, ex_MtoR, ex_regwrite, ex_memread,
               ex_memwrite, ex_branch, ex_jump, ex_illegal, ex_rd, ex_rs1, ex_rs2, stall
    );

    modport slave (
        input  id_valid, id_instr, flush,
        output id_ready, ex_valid, ex_ALUop, ex_ALUsrc, ex_MtoR, ex_regwrite, ex_memread,
               ex_memwrite, ex_branch, ex_jump, ex_illegal, ex_rd, ex_rs1, ex_rs2, stall
    );
endinterface

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered decode stage. Decodes id_instr into EX control,
// latches it with rd/rs1/rs2 into the ID/EX register, inserts LOAD_LAT bubbles on
// a load-use hazard and kills the ID/EX contents on flush.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ctrl_decode_if.slave (id handshake, flush, ex_* outputs, stall)
module ctrl_decode_stage #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned EXT_OPS  = 1,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    ctrl_decode_if.slave bus
);
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    typedef struct packed {
        logic              valid;
        logic [1:0]        alu_op;
        logic              alu_src;
        logic              mem_to_reg;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic              branch;
        logic              jump;
        logic              illegal;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } ex_t;

    typedef enum logic [0:0] {StRun, StStall} state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    ex_t        ex_q, ex_d;
    ex_t        dec;
    logic       rs1_used, rs2_used;
    logic       hazard;
    logic       unused_instr;

    assign unused_instr = ^{bus.id_instr[31:25], bus.id_instr[14:12]};

    // Combinational decode of the instruction sitting in IF/ID.
    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.rd       = REG_AW'(bus.id_instr[11:7]);
        dec.rs1      = REG_AW'(bus.id_instr[19:15]);
        dec.rs2      = REG_AW'(bus.id_instr[24:20]);
        rs1_used     = 1'b1;
        rs2_used     = 1'b0;
        case (bus.id_instr[6:0])
            OpR: begin
                dec.alu_op   = 2'b10;
                dec.regwrite = 1'b1;
                rs2_used     = 1'b1;
            end
            OpBranch: begin
                dec.alu_op = 2'b01;
                dec.branch = 1'b1;
                rs2_used   = 1'b1;
            end
            OpLoad: begin
                dec.alu_src    = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.regwrite   = 1'b1;
                dec.memread    = 1'b1;
            end
            OpStore: begin
                dec.alu_src  = 1'b1;
                dec.memwrite = 1'b1;
                rs2_used     = 1'b1;
            end
            OpImm: begin
                dec.alu_op   = 2'b11;
                dec.alu_src  = 1'b1;
                dec.regwrite = 1'b1;
            end
            OpLui, OpAuipc: begin
                rs1_used = 1'b0;
                if (EXT_OPS != 0) begin
                    dec.alu_src  = 1'b1;
                    dec.regwrite = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OpJal, OpJalr: begin
                rs1_used = (bus.id_instr[6:0] == OpJalr);
                if (EXT_OPS != 0) begin
                    dec.alu_src  = 1'b1;
                    dec.regwrite = 1'b1;
                    dec.jump     = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // A load in EX whose destination the ID instruction reads (x0 never hazards).
    assign hazard = ex_q.valid & ex_q.memread & (ex_q.rd != '0) & bus.id_valid &
                    ((rs1_used & (ex_q.rd == dec.rs1)) | (rs2_used & (ex_q.rd == dec.rs2)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ex_d         = '0;
        bus.id_ready = 1'b0;
        bus.stall    = 1'b0;
        case (state_q)
            StRun: begin
                bus.stall    = hazard;
                bus.id_ready = ~hazard & ~bus.flush;
                if (hazard) begin
                    // This cycle's bubble is the first; cnt holds the ones still owed.
                    cnt_d = 3'(LOAD_LAT - 1);
                    if (LOAD_LAT > 1) begin
                        state_d = StStall;
                    end
                end else if (bus.id_valid) begin
                    ex_d = dec;
                end
            end
            StStall: begin
                bus.stall = 1'b1;
                if (cnt_q <= 3'd1) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase
        if (bus.flush) begin
            ex_d    = '0;
            state_d = StRun;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            cnt_q   <= '0;
            ex_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
        end
    end

    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_ALUop    = ex_q.alu_op;
    assign bus.ex_ALUsrc   = ex_q.alu_src;
    assign bus.ex_MtoR     = ex_q.mem_to_reg;
    assign bus.ex_regwrite = ex_q.regwrite;
    assign bus.ex_memread  = ex_q.memread;
    assign bus.ex_memwrite = ex_q.memwrite;
    assign bus.ex_branch   = ex_q.branch;
    assign bus.ex_jump     = ex_q.jump;
    assign bus.ex_illegal  = ex_q.illegal;
    assign bus.ex_rd       = ex_q.rd;
    assign bus.ex_rs1      = ex_q.rs1;
    assign bus.ex_rs2      = ex_q.rs2;
endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench: three decode stages (LOAD_LAT=1/EXT_OPS=1, LOAD_LAT=3/EXT_OPS=1,
// LOAD_LAT=1/EXT_OPS=0) each checked every cycle against a reference model,
// plus directed scenarios with hand-computed expectations.
module tb_ctrl_decode_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        valid = '0;
    logic [2:0]        flush = '0;
    logic [2:0][31:0]  instr = '0;
    logic [2:0]        rdy;
    logic [2:0]        stl;
    logic [2:0][25:0]  obs;

    int checks = 0;
    int passes = 0;

    // Model state: expected ID/EX contents and bubbles still owed per instance.
    logic [25:0] m_ex   [3];
    int          m_left [3];
    logic        m_acc  [3];

    localparam logic [31:0] ADD_3_1_2 = 32'h002081B3;
    localparam logic [31:0] LW_5_1    = 32'h0000A283;
    localparam logic [31:0] ADD_6_5_7 = 32'h00728333;
    localparam logic [31:0] LW_0_1    = 32'h00008003;
    localparam logic [31:0] ADD_6_0_7 = 32'h00700333;
    localparam logic [31:0] LUI_5     = 32'h000282B7;
    localparam logic [31:0] JAL_0     = 32'h0000006F;

    for (genvar g = 0; g < 3; g++) begin : gi
        ctrl_decode_if #(.REG_AW(5)) bus ();
        ctrl_decode_stage #(
            .REG_AW  (5),
            .EXT_OPS ((g == 2) ? 0 : 1),
            .LOAD_LAT((g == 1) ? 3 : 1)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus.slave)
        );
        assign bus.id_valid = valid[g];
        assign bus.id_instr = instr[g];
        assign bus.flush    = flush[g];
        assign rdy[g]       = bus.id_ready;
        assign stl[g]       = bus.stall;
        assign obs[g] = {bus.ex_valid, bus.ex_ALUop, bus.ex_ALUsrc, bus.ex_MtoR, bus.ex_regwrite,
                         bus.ex_memread, bus.ex_memwrite, bus.ex_branch, bus.ex_jump,
                         bus.ex_illegal, bus.ex_rd, bus.ex_rs1, bus.ex_rs2};
    end

    function automatic int lat_of(input int i);
        return (i == 1) ? 3 : 1;
    endfunction

    function automatic bit ext_of(input int i);
        return (i != 2);
    endfunction

    // Decode table straight from the opcode list.
    function automatic logic [25:0] dec_m(input logic [31:0] ins, input bit ext);
        logic [1:0] aop;
        logic src, mtor, rw, mr, mw, br, jp, ill;
        aop = 2'b00; {src, mtor, rw, mr, mw, br, jp, ill} = 8'b0;
        case (ins[6:0])
            7'h33: begin aop = 2'b10; rw = 1; end
            7'h63: begin aop = 2'b01; br = 1; end
            7'h03: begin src = 1; mtor = 1; rw = 1; mr = 1; end
            7'h23: begin src = 1; mw = 1; end
            7'h13: begin aop = 2'b11; src = 1; rw = 1; end
            7'h37, 7'h17: if (ext) begin src = 1; rw = 1; end else ill = 1;
            7'h6F, 7'h67: if (ext) begin src = 1; rw = 1; jp = 1; end else ill = 1;
            default: ill = 1;
        endcase
        return {1'b1, aop, src, mtor, rw, mr, mw, br, jp, ill, ins[11:7], ins[19:15], ins[24:20]};
    endfunction

    function automatic bit hazard_m(input int i, input logic v, input logic [31:0] ins);
        logic [6:0]  op;
        logic [25:0] e;
        bit r1, r2;
        op = ins[6:0];
        e  = m_ex[i];
        r1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        r2 = (op == 7'h33 || op == 7'h63 || op == 7'h23);
        return e[25] && e[19] && (e[14:10] != 5'd0) && v &&
               ((r1 && e[14:10] == ins[19:15]) || (r2 && e[14:10] == ins[24:20]));
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_ex[i] = '0; m_left[i] = 0; m_acc[i] = 1'b0;
        end
    endtask

    // One clock: drive at the falling edge, check, then advance the model.
    task automatic tick(input logic [2:0] v, input logic [2:0][31:0] ins, input logic [2:0] fl);
        bit hz;
        bit er;
        @(negedge clk);
        valid = v; instr = ins; flush = fl;
        #1;
        for (int i = 0; i < 3; i++) begin
            hz = hazard_m(i, v[i], ins[i]);
            er = !fl[i] && m_left[i] == 0 && !hz;
            chk($sformatf("ready%0d", i), 32'(rdy[i]), 32'(er));
            chk($sformatf("stall%0d", i), 32'(stl[i]), 32'(m_left[i] > 0 || hz));
            chk($sformatf("ex%0d", i), 32'(obs[i]), 32'(m_ex[i]));
            m_acc[i] = v[i] && er;
            if (fl[i]) begin
                m_ex[i] = '0; m_left[i] = 0;
            end else if (m_left[i] > 0) begin
                m_ex[i] = '0; m_left[i]--;
            end else if (hz) begin
                m_ex[i] = '0; m_left[i] = lat_of(i) - 1;
            end else if (v[i]) begin
                m_ex[i] = dec_m(ins[i], ext_of(i));
            end else begin
                m_ex[i] = '0;
            end
        end
    endtask

    task automatic tick3(input logic v, input logic [31:0] ins, input logic fl);
        tick({3{v}}, {3{ins}}, {3{fl}});
    endtask

    logic [6:0]       ops [10];
    logic [2:0]       rv;
    logic [2:0]       rf;
    logic [2:0][31:0] ri;
    logic [31:0]      r;
    int               scnt [3];

    initial begin
        ops = '{7'h33, 7'h63, 7'h03, 7'h23, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h0B};
        model_reset();
        rv = '0; rf = '0; ri = '0;

        // Reset values.
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ex", 32'(obs), 32'd0);
        chk("reset_stall", 32'(stl), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: add x3,x1,x2.
        tick3(1'b1, ADD_3_1_2, 1'b0);
        tick3(1'b0, 32'd0, 1'b0);
        chk("t1_add", 32'(obs[0]), 32'({1'b1, 2'b10, 8'b00100000, 5'd3, 5'd1, 5'd2}));

        // T2/T3: lw x5 then dependent add; count stall cycles.
        tick3(1'b1, LW_5_1, 1'b0);
        for (int i = 0; i < 3; i++) scnt[i] = 0;
        for (int k = 0; k < 5; k++) begin
            tick3(1'b1, ADD_6_5_7, 1'b0);
            for (int i = 0; i < 3; i++) scnt[i] += int'(stl[i]);
        end
        chk("t2_stall_lat1", 32'(scnt[0]), 32'd1);
        chk("t3_stall_lat3", 32'(scnt[1]), 32'd3);
        tick3(1'b0, 32'd0, 1'b0);

        // T4: loads to x0, and lui not reading rs1, never stall.
        tick3(1'b1, LW_0_1, 1'b0);
        tick3(1'b1, ADD_6_0_7, 1'b0);
        chk("t4_x0", 32'(stl), 32'd0);
        tick3(1'b1, LW_5_1, 1'b0);
        tick3(1'b1, LUI_5, 1'b0);
        chk("t4_lui", 32'(stl), 32'd0);

        // T5: flush during the LOAD_LAT=3 stall.
        tick3(1'b1, LW_5_1, 1'b0);
        tick3(1'b1, ADD_6_5_7, 1'b0);
        tick3(1'b1, ADD_6_5_7, 1'b1);
        chk("t5_in_stall", 32'(stl[1]), 32'd1);
        tick3(1'b1, ADD_6_5_7, 1'b0);
        chk("t5_ready", 32'({rdy[1], stl[1]}), 32'b10);
        tick3(1'b0, 32'd0, 1'b0);
        chk("t5_issued", 32'({obs[1][25], obs[1][14:10]}), 32'({1'b1, 5'd6}));

        // T6: jal with and without extended ops.
        tick3(1'b1, JAL_0, 1'b0);
        tick3(1'b0, 32'd0, 1'b0);
        chk("t6_jal_ext1", 32'(obs[0]), 32'({1'b1, 2'b00, 8'b10100010, 15'd0}));
        chk("t6_jal_ext0", 32'(obs[2]), 32'({1'b1, 2'b00, 8'b00000001, 15'd0}));

        // T7: asynchronous reset in the middle of the LOAD_LAT=3 stall.
        tick3(1'b1, LW_5_1, 1'b0);
        tick3(1'b1, ADD_6_5_7, 1'b0);
        tick3(1'b1, ADD_6_5_7, 1'b0);
        tick3(1'b0, 32'd0, 1'b0);
        chk("t7_pre", 32'({stl[1], obs[0][25]}), 32'b11);
        rst_n = 1'b0;
        #1;
        chk("t7_ex", 32'(obs), 32'd0);
        chk("t7_stall", 32'(stl), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic; an un-accepted valid instruction is held.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!(rv[i] && !m_acc[i] && !rf[i])) begin
                    rv[i] = ($urandom_range(9) < 8);
                    r = $urandom();
                    r[6:0]   = ops[$urandom_range(9)];
                    r[11:7]  = 5'($urandom_range(3));
                    r[19:15] = 5'($urandom_range(3));
                    r[24:20] = 5'($urandom_range(3));
                    ri[i] = r;
                end
            end
            for (int i = 0; i < 3; i++) rf[i] = ($urandom_range(15) == 0);
            tick(rv, ri, rf);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
